// File: rtl/adc_reader_if.sv
// adc_reader_if: serial ADC link plus captured-sample outputs.
// master = reader side, slave = ADC/consumer side.
interface adc_reader_if;
   logic        EN;
   logic        MISO;
   logic        SCK;
   logic        CS;
   logic [11:0] SAMPLE;
   logic        VALID;
   logic        ERR;

   modport master (
      input  EN, MISO,
      output SCK, CS, SAMPLE, VALID, ERR
   );

   modport slave (
      output EN, MISO,
      input  SCK, CS, SAMPLE, VALID, ERR
   );
endinterface

// File: rtl/adc_reader.sv
// adc_reader: periodic 16-clock SPI read of a 12-bit serial ADC.
// Optional ADC_SIGNED_EN: present SAMPLE as two's complement.
module adc_reader #(
   parameter int CLK_DIV    = 4,
   parameter int SAMPLE_DIV = 2267
) (
   input logic        CLK,
   input logic        RST,
   adc_reader_if.master bus
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SETUP = 2'd1;
   localparam logic [1:0] SHIFT = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   localparam int TW = $clog2(SAMPLE_DIV);
   localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_DIV - 1);
   localparam logic [7:0]    PH_LAST   = 8'(CLK_DIV - 1);

   logic [1:0]    state;
   logic [TW-1:0] tick_cnt;
   logic [7:0]    phase;
   logic [4:0]    bit_cnt;
   logic [15:0]   shift;
   logic          sck;
   logic [11:0]   sample;
   logic          valid;
   logic          err;
   logic          tick;
   logic [11:0]   code;

   assign tick = (tick_cnt == '0);

`ifdef ADC_SIGNED_EN
   assign code = {~shift[11], shift[10:0]};
`else
   assign code = shift[11:0];
`endif

   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= IDLE;
         tick_cnt <= '0;
         phase    <= '0;
         bit_cnt  <= '0;
         shift    <= '0;
         sck      <= 1'b1;
         sample   <= '0;
         valid    <= 1'b0;
         err      <= 1'b0;
      end else begin
         valid    <= 1'b0;
         tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + TW'(1);
         unique case (state)
            IDLE: begin
               if (tick && bus.EN) begin
                  state <= SETUP;
                  phase <= '0;
               end
            end
            SETUP: begin
               if (phase == PH_LAST) begin
                  state   <= SHIFT;
                  phase   <= '0;
                  bit_cnt <= '0;
                  sck     <= 1'b0;
               end else begin
                  phase <= phase + 8'd1;
               end
            end
            SHIFT: begin
               if (phase != PH_LAST) begin
                  phase <= phase + 8'd1;
               end else begin
                  phase <= '0;
                  // capture on the edge that raises SCK
                  if (!sck) begin
                     sck     <= 1'b1;
                     shift   <= {shift[14:0], bus.MISO};
                     bit_cnt <= bit_cnt + 5'd1;
                  end else if (bit_cnt == 5'd16) begin
                     state  <= DONE;
                     valid  <= 1'b1;
                     sample <= code;
                     err    <= |shift[15:12];
                  end else begin
                     sck <= 1'b0;
                  end
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.CS     = !((state == SETUP) || (state == SHIFT));
   assign bus.SCK    = (state == SHIFT) ? sck : 1'b1;
   assign bus.SAMPLE = sample;
   assign bus.VALID  = valid;
   assign bus.ERR    = err;

endmodule

// File: tb/tb_adc_reader.sv
// tb_adc_reader: directed checks of adc_reader against a behavioural ADC.
// Also runs an instance with a too-short sample period.
module tb_adc_reader;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   always #5 CLK = ~CLK;

   adc_reader_if bus ();
   adc_reader_if bus6 ();

   adc_reader #(.CLK_DIV(2), .SAMPLE_DIV(100)) u_dut (
      .CLK(CLK), .RST(RST), .bus(bus)
   );
   adc_reader #(.CLK_DIV(2), .SAMPLE_DIV(40)) u_fast (
      .CLK(CLK), .RST(RST), .bus(bus6)
   );

   // ADC model: bit 15-n on MISO after n SCK rises in the frame
   logic [15:0] word  = 16'h0A5C;
   logic [15:0] word6 = 16'h0ABC;
   int nr  = 0;
   int nr6 = 0;
   always @(posedge bus.SCK or posedge bus.CS)
      if (bus.CS) nr = 0; else nr = nr + 1;
   always @(posedge bus6.SCK or posedge bus6.CS)
      if (bus6.CS) nr6 = 0; else nr6 = nr6 + 1;
   assign bus.MISO  = (nr < 16) ? word[15-nr] : 1'b0;
   assign bus6.MISO = (nr6 < 16) ? word6[15-nr6] : 1'b0;

   int mcnt = 0;
   logic rst_q = 1'b1;
   always @(posedge CLK) begin
      rst_q <= RST;
      if (RST) mcnt <= 0;
      else mcnt <= (mcnt == 99) ? 0 : mcnt + 1;
   end

   int viol = 0;
   int dv = 0;
   logic pcs = 1, psck = 1, pv = 0;
   logic pcs6 = 1, psck6 = 1, pv6 = 0;
   always @(negedge CLK) begin
      if (!rst_q) begin
         if (bus.CS && !bus.SCK) viol++;
         if (bus.CS != pcs && !(bus.SCK && psck)) viol++;
         if (bus.VALID && pv) dv++;
         if (bus6.CS && !bus6.SCK) viol++;
         if (bus6.CS != pcs6 && !(bus6.SCK && psck6)) viol++;
         if (bus6.VALID && pv6) dv++;
      end
      pcs = bus.CS; psck = bus.SCK; pv = bus.VALID;
      pcs6 = bus6.CS; psck6 = bus6.SCK; pv6 = bus6.VALID;
   end

   int nvec = 0;
   int nerr = 0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge CLK);
   endtask

   function automatic logic hit(input int sel);
      case (sel)
         0: return bus.VALID;
         1: return !bus.CS;
         default: return bus6.VALID;
      endcase
   endfunction

   task automatic wait_for(input string tag, input int sel,
                           input int bound, output int n);
      n = 0;
      do begin
         step(1);
         n++;
      end while (!hit(sel) && n < bound);
      chk({tag, "_seen"}, 32'(hit(sel)), 32'd1);
   endtask

   function automatic logic [11:0] conv(input logic [11:0] x);
`ifdef ADC_SIGNED_EN
      return {~x[11], x[10:0]};
`else
      return x;
`endif
   endfunction

   initial begin
      int n;
      int cs_low, rises, first_low, vcyc;
      logic ps;

      bus.EN = 1'b1;
      bus6.EN = 1'b1;
      step(3);
      RST = 1'b0;
      chk("rst_cs", 32'(bus.CS), 32'd1);
      chk("rst_sck", 32'(bus.SCK), 32'd1);
      chk("rst_sample", 32'(bus.SAMPLE), 32'd0);
      chk("rst_valid", 32'(bus.VALID), 32'd0);
      chk("rst_err", 32'(bus.ERR), 32'd0);

      // frame 1: tick in cycle 0
      cs_low = 0; rises = 0; first_low = 0; vcyc = 0; ps = 1'b1;
      for (int i = 1; i <= 67; i++) begin
         step(1);
         if (!bus.CS) cs_low++;
         if (!bus.CS && first_low == 0) first_low = i;
         if (bus.SCK && !ps) rises++;
         ps = bus.SCK;
         if (bus.VALID && vcyc == 0) vcyc = i;
      end
      chk("t1_cs_fall", 32'(first_low), 32'd1);
      chk("t1_cs_low", 32'(cs_low), 32'd66);
      chk("t1_sck_rises", 32'(rises), 32'd16);
      chk("t1_valid_cyc", 32'(vcyc), 32'd67);
      chk("t1_sample", 32'(bus.SAMPLE), 32'(conv(12'hA5C)));
      chk("t1_err", 32'(bus.ERR), 32'd0);
      step(1);
      chk("t1_valid_1cyc", 32'(bus.VALID), 32'd0);

      // nonzero leading bits
      word = 16'h4FFF;
      wait_for("t2a", 0, 200, n);
      chk("t2a_period", 32'(n), 32'd99);
      chk("t2a_sample", 32'(bus.SAMPLE), 32'(conv(12'hFFF)));
      chk("t2a_err", 32'(bus.ERR), 32'd1);
      word = 16'h0123;
      wait_for("t2b", 0, 200, n);
      chk("t2b_period", 32'(n), 32'd100);
      chk("t2b_sample", 32'(bus.SAMPLE), 32'(conv(12'h123)));
      chk("t2b_err", 32'(bus.ERR), 32'd0);

      // EN low: no frames
      bus.EN = 1'b0;
      cs_low = 0;
      for (int i = 0; i < 300; i++) begin
         step(1);
         if (!bus.CS) cs_low++;
      end
      chk("t3_idle_cs", 32'(cs_low), 32'd0);
      bus.EN = 1'b1;
      wait_for("t3_cs", 1, 200, n);
      chk("t3_after_tick", 32'(mcnt), 32'd1);
      step(9);
      bus.EN = 1'b0;
      wait_for("t3_v", 0, 200, n);
      chk("t3_drop_en_lat", 32'(n), 32'd57);
      chk("t3_sample", 32'(bus.SAMPLE), 32'(conv(12'h123)));

      // reset during bit 7
      bus.EN = 1'b1;
      word = 16'h0555;
      wait_for("t4_cs", 1, 200, n);
      chk("t4_after_tick", 32'(mcnt), 32'd1);
      step(31);
      chk("t4_bit7_sck", 32'(bus.SCK), 32'd0);
      RST = 1'b1;
      step(1);
      RST = 1'b0;
      chk("t4_cs", 32'(bus.CS), 32'd1);
      chk("t4_sck", 32'(bus.SCK), 32'd1);
      chk("t4_valid", 32'(bus.VALID), 32'd0);
      chk("t4_sample", 32'(bus.SAMPLE), 32'd0);
      chk("t4_err", 32'(bus.ERR), 32'd0);
      wait_for("t4_v", 0, 200, n);
      chk("t4_lat", 32'(n), 32'd67);
      chk("t4_new_sample", 32'(bus.SAMPLE), 32'(conv(12'h555)));
      word = 16'h0000;

      // free-run 10 frames
      for (int k = 0; k < 10; k++) begin
         wait_for("t5_v", 0, 200, n);
         chk("t5_period", 32'(n), 32'd100);
         chk("t5_sample", 32'(bus.SAMPLE), 32'(conv(12'(k))));
         word = 16'(k + 1);
      end

      // short SAMPLE_DIV instance
      for (int j = 0; j < 3; j++) begin
         wait_for("t6_v", 2, 200, n);
         if (j > 0) chk("t6_period", 32'(n), 32'd80);
         chk("t6_sample", 32'(bus6.SAMPLE), 32'(conv(12'hABC)));
         chk("t6_err", 32'(bus6.ERR), 32'd0);
      end

      chk("sck_cs_rules", 32'(viol), 32'd0);
      chk("valid_single", 32'(dv), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
